// File: rtl/merge_pkg.sv
// Shared types for the merge scheduler: FSM state encoding and the queued job record.
// job_t field widths track the scheduler's default ADDR_WIDTH / ID_WIDTH.
package merge_pkg;

   localparam int JOB_ADDR_W = 16;
   localparam int JOB_ID_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_RUN    = 2'd2,
      ST_REPORT = 2'd3
   } sched_state_t;

   typedef struct packed {
      logic [JOB_ADDR_W-1:0] src0;
      logic [JOB_ADDR_W-1:0] src1;
      logic [JOB_ADDR_W-1:0] dst;
      logic [JOB_ID_W-1:0]   id;
   } job_t;

endpackage

// File: rtl/merge_scheduler_if.sv
// Job request, engine control and completion signals of the merge scheduler.
// slave is the scheduler side, master the requester/engine/consumer side.
interface merge_scheduler_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int ID_WIDTH   = 4
) ();

   logic                  job_valid;
   logic                  job_ready;
   logic [ADDR_WIDTH-1:0] job_src0_addr;
   logic [ADDR_WIDTH-1:0] job_src1_addr;
   logic [ADDR_WIDTH-1:0] job_dst_addr;
   logic [ID_WIDTH-1:0]   job_id;

   logic                  eng_run;
   logic [ADDR_WIDTH-1:0] eng_src0_addr;
   logic [ADDR_WIDTH-1:0] eng_src1_addr;
   logic [ADDR_WIDTH-1:0] eng_dst_addr;
   logic                  eng_done;

   logic                  cmp_valid;
   logic                  cmp_ready;
   logic [ID_WIDTH-1:0]   cmp_id;
   logic                  cmp_timeout;

   logic                  busy;

   modport slave (
      input  job_valid, job_src0_addr, job_src1_addr, job_dst_addr, job_id,
      input  eng_done, cmp_ready,
      output job_ready, eng_run, eng_src0_addr, eng_src1_addr, eng_dst_addr,
      output cmp_valid, cmp_id, cmp_timeout, busy
   );

   modport master (
      output job_valid, job_src0_addr, job_src1_addr, job_dst_addr, job_id,
      output eng_done, cmp_ready,
      input  job_ready, eng_run, eng_src0_addr, eng_src1_addr, eng_dst_addr,
      input  cmp_valid, cmp_id, cmp_timeout, busy
   );

endinterface

// File: rtl/merge_scheduler_job_fifo.sv
// Job queue: registered-memory FIFO without fall-through; a write becomes
// readable the cycle after it is pushed.
module job_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/merge_scheduler.sv
// Merge scheduler: queues merge jobs, launches them one at a time on the engine,
// guards each with a watchdog and reports completion with the job tag.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a queued job; pops it into the active registers
//   ST_LAUNCH | eng_run high for this single cycle, first engine cycle
//   ST_RUN    | waiting for eng_done or watchdog expiry
//   ST_REPORT | completion record held until cmp_ready
module merge_scheduler
   import merge_pkg::*;
#(
   parameter int ADDR_WIDTH     = JOB_ADDR_W,
   parameter int ID_WIDTH       = JOB_ID_W,
   parameter int QUEUE_DEPTH    = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic              clk,
   input logic              reset_n,
   merge_scheduler_if.slave bus
);

   localparam int          WD_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   sched_state_t    state_q;
   job_t            act_q;
   job_t            wr_job;
   job_t            rd_job;
   logic [WD_W-1:0] wd_cnt_q;
   logic            eng_run_q;
   logic            cmp_valid_q;
   logic [ID_WIDTH-1:0] cmp_id_q;
   logic            cmp_timeout_q;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;

   always_comb begin
      wr_job      = '0;
      wr_job.src0 = JOB_ADDR_W'(bus.job_src0_addr);
      wr_job.src1 = JOB_ADDR_W'(bus.job_src1_addr);
      wr_job.dst  = JOB_ADDR_W'(bus.job_dst_addr);
      wr_job.id   = JOB_ID_W'(bus.job_id);
   end

   assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

   job_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH ($bits(job_t))
   ) u_job_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (bus.job_valid),
      .wr_data (wr_job),
      .pop     (fifo_pop),
      .rd_data (rd_job),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // The counter is zero during LAUNCH, which counts as engine cycle one,
   // so expiry lands exactly TIMEOUT_CYCLES cycles after the eng_run pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         act_q         <= '0;
         wd_cnt_q      <= '0;
         eng_run_q     <= 1'b0;
         cmp_valid_q   <= 1'b0;
         cmp_id_q      <= '0;
         cmp_timeout_q <= 1'b0;
      end else begin
         eng_run_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  act_q     <= rd_job;
                  wd_cnt_q  <= '0;
                  eng_run_q <= 1'b1;
                  state_q   <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               wd_cnt_q <= WD_W'(1);
               state_q  <= ST_RUN;
            end
            ST_RUN: begin
               if (bus.eng_done) begin
                  cmp_valid_q   <= 1'b1;
                  cmp_timeout_q <= 1'b0;
                  cmp_id_q      <= ID_WIDTH'(act_q.id);
                  state_q       <= ST_REPORT;
               end else if (wd_cnt_q == WD_LAST) begin
                  cmp_valid_q   <= 1'b1;
                  cmp_timeout_q <= 1'b1;
                  cmp_id_q      <= ID_WIDTH'(act_q.id);
                  state_q       <= ST_REPORT;
               end else begin
                  wd_cnt_q <= wd_cnt_q + 1'b1;
               end
            end
            ST_REPORT: begin
               if (bus.cmp_ready) begin
                  cmp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.job_ready     = !fifo_full;
   assign bus.eng_run       = eng_run_q;
   assign bus.eng_src0_addr = ADDR_WIDTH'(act_q.src0);
   assign bus.eng_src1_addr = ADDR_WIDTH'(act_q.src1);
   assign bus.eng_dst_addr  = ADDR_WIDTH'(act_q.dst);
   assign bus.cmp_valid     = cmp_valid_q;
   assign bus.cmp_id        = cmp_id_q;
   assign bus.cmp_timeout   = cmp_timeout_q;
   assign bus.busy          = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_merge_scheduler.sv
// Directed bench for merge_scheduler: latency, queue back-pressure, watchdog,
// completion hold, mid-job reset and eng_done filtering.
module tb_merge_scheduler;

   localparam int AW = 16;
   localparam int IW = 4;
   localparam int TC = 16;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   merge_scheduler_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

   merge_scheduler #(
      .ADDR_WIDTH     (AW),
      .ID_WIDTH       (IW),
      .QUEUE_DEPTH    (4),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_job(input logic [IW-1:0] id, input logic [AW-1:0] s0,
                            input logic [AW-1:0] s1, input logic [AW-1:0] d);
      bus.job_valid     = 1'b1;
      bus.job_id        = id;
      bus.job_src0_addr = s0;
      bus.job_src1_addr = s1;
      bus.job_dst_addr  = d;
   endtask

   task automatic wait_run(input string tag);
      int n = 0;
      while (bus.eng_run !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (bus.eng_run !== 1'b1) begin
         errors++;
         $display("FAIL %s eng_run got %b want 1 within 60 cycles", tag, bus.eng_run);
      end
   endtask

   // Launch-to-done in `delay` cycles; leaves the FSM in REPORT when ack is 0.
   task automatic complete_job(input logic [IW-1:0] id, input logic [AW-1:0] s0,
                               input int delay, input bit ack);
      wait_run($sformatf("run_id%0d", id));
      checks++;
      if (bus.eng_src0_addr !== s0) begin
         errors++;
         $display("FAIL src0_id%0d got %h want %h", id, bus.eng_src0_addr, s0);
      end
      for (int i = 0; i < delay; i++) begin
         tick();
         bus.job_valid = 1'b0;
      end
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      checks++;
      if (bus.cmp_valid !== 1'b1 || bus.cmp_id !== id || bus.cmp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL cmp_id%0d got v=%b id=%0d to=%b want v=1 id=%0d to=0",
                  id, bus.cmp_valid, bus.cmp_id, bus.cmp_timeout, id);
      end
      if (ack) begin
         bus.cmp_ready = 1'b1;
         tick();
         bus.cmp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.eng_run !== 1'b0 || bus.cmp_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.cmp_timeout !== 1'b0 || bus.cmp_id !== '0) begin
         errors++;
         $display("FAIL reset_ctrl got run=%b cv=%b busy=%b to=%b id=%0d want all 0",
                  bus.eng_run, bus.cmp_valid, bus.busy, bus.cmp_timeout, bus.cmp_id);
      end
      checks++;
      if (bus.eng_src0_addr !== '0 || bus.eng_src1_addr !== '0 || bus.eng_dst_addr !== '0) begin
         errors++;
         $display("FAIL reset_addr got %h %h %h want 0", bus.eng_src0_addr,
                  bus.eng_src1_addr, bus.eng_dst_addr);
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got ready=%b busy=%b want 1 0", bus.job_ready, bus.busy);
      end
   endtask

   task automatic test_single();
      drive_job(4'd3, 16'h0000, 16'h0100, 16'h0200);
      checks++;
      if (bus.job_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready got %b want 1", bus.job_ready);
      end
      tick();
      bus.job_valid = 1'b0;
      checks++;
      if (bus.eng_run !== 1'b0) begin
         errors++;
         $display("FAIL single_t1 eng_run got %b want 0", bus.eng_run);
      end
      tick();
      checks++;
      if (bus.eng_run !== 1'b1 || bus.eng_src0_addr !== 16'h0000 ||
          bus.eng_src1_addr !== 16'h0100 || bus.eng_dst_addr !== 16'h0200) begin
         errors++;
         $display("FAIL single_t2 got run=%b %h %h %h want 1 0000 0100 0200", bus.eng_run,
                  bus.eng_src0_addr, bus.eng_src1_addr, bus.eng_dst_addr);
      end
      tick();
      checks++;
      if (bus.eng_run !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse eng_run got %b want 0", bus.eng_run);
      end
      repeat (9) tick();
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      checks++;
      if (bus.cmp_valid !== 1'b1 || bus.cmp_id !== 4'd3 || bus.cmp_timeout !== 1'b0 ||
          bus.eng_dst_addr !== 16'h0200) begin
         errors++;
         $display("FAIL single_cmp got v=%b id=%0d to=%b dst=%h want 1 3 0 0200",
                  bus.cmp_valid, bus.cmp_id, bus.cmp_timeout, bus.eng_dst_addr);
      end
      bus.cmp_ready = 1'b1;
      tick();
      bus.cmp_ready = 1'b0;
      checks++;
      if (bus.cmp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.eng_src1_addr !== 16'h0100) begin
         errors++;
         $display("FAIL single_idle got v=%b busy=%b src1=%h want 0 0 0100",
                  bus.cmp_valid, bus.busy, bus.eng_src1_addr);
      end
   endtask

   task automatic test_back_to_back();
      drive_job(4'd15, 16'h00F0, 16'h10F0, 16'h20F0);
      tick();
      bus.job_valid = 1'b0;
      wait_run("b2b_launch15");
      for (int i = 0; i < 5; i++) begin
         drive_job(IW'(i), AW'(i * 16), 16'h1000, 16'h2000);
         checks++;
         if (bus.job_ready !== (i < 4)) begin
            errors++;
            $display("FAIL b2b_ready%0d got %b want %b", i, bus.job_ready, (i < 4));
         end
         tick();
      end
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      checks++;
      if (bus.cmp_valid !== 1'b1 || bus.cmp_id !== 4'd15) begin
         errors++;
         $display("FAIL b2b_cmp15 got v=%b id=%0d want 1 15", bus.cmp_valid, bus.cmp_id);
      end
      bus.cmp_ready = 1'b1;
      tick();
      bus.cmp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         complete_job(IW'(i), AW'(i * 16), 3, 1'b1);
      end
   endtask

   task automatic test_timeout();
      drive_job(4'd7, 16'h0700, 16'h1700, 16'h2700);
      tick();
      drive_job(4'd8, 16'h0800, 16'h1800, 16'h2800);
      tick();
      bus.job_valid = 1'b0;
      wait_run("to_launch7");
      repeat (TC - 1) tick();
      checks++;
      if (bus.cmp_valid !== 1'b0) begin
         errors++;
         $display("FAIL to_early cmp_valid got %b want 0", bus.cmp_valid);
      end
      tick();
      checks++;
      if (bus.cmp_valid !== 1'b1 || bus.cmp_timeout !== 1'b1 || bus.cmp_id !== 4'd7) begin
         errors++;
         $display("FAIL to_fire got v=%b to=%b id=%0d want 1 1 7",
                  bus.cmp_valid, bus.cmp_timeout, bus.cmp_id);
      end
      bus.cmp_ready = 1'b1;
      tick();
      bus.cmp_ready = 1'b0;
      complete_job(4'd8, 16'h0800, 5, 1'b1);
   endtask

   task automatic test_report_hold();
      drive_job(4'd9, 16'h0900, 16'h1900, 16'h2900);
      tick();
      drive_job(4'd10, 16'h0A00, 16'h1A00, 16'h2A00);
      tick();
      bus.job_valid = 1'b0;
      complete_job(4'd9, 16'h0900, 2, 1'b0);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (bus.cmp_valid !== 1'b1 || bus.cmp_id !== 4'd9 || bus.eng_run !== 1'b0 ||
             bus.eng_src0_addr !== 16'h0900) begin
            errors++;
            $display("FAIL hold%0d got v=%b id=%0d run=%b src0=%h want 1 9 0 0900", i,
                     bus.cmp_valid, bus.cmp_id, bus.eng_run, bus.eng_src0_addr);
         end
         tick();
      end
      bus.cmp_ready = 1'b1;
      tick();
      bus.cmp_ready = 1'b0;
      complete_job(4'd10, 16'h0A00, 4, 1'b1);
   endtask

   task automatic test_reset_mid();
      bit saw_run = 1'b0;
      bit saw_cmp = 1'b0;
      drive_job(4'd11, 16'h0B00, 16'h1B00, 16'h2B00);
      tick();
      drive_job(4'd12, 16'h0C00, 16'h1C00, 16'h2C00);
      tick();
      drive_job(4'd13, 16'h0D00, 16'h1D00, 16'h2D00);
      tick();
      bus.job_valid = 1'b0;
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.eng_src0_addr !== 16'h0B00) begin
         errors++;
         $display("FAIL mid_pre got busy=%b src0=%h want 1 0B00", bus.busy, bus.eng_src0_addr);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.eng_run !== 1'b0 || bus.cmp_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.cmp_id !== '0 || bus.cmp_timeout !== 1'b0 || bus.eng_src0_addr !== '0 ||
          bus.eng_src1_addr !== '0 || bus.eng_dst_addr !== '0) begin
         errors++;
         $display("FAIL mid_reset got run=%b cv=%b busy=%b id=%0d src0=%h want all 0",
                  bus.eng_run, bus.cmp_valid, bus.busy, bus.cmp_id, bus.eng_src0_addr);
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_release got ready=%b busy=%b want 1 0", bus.job_ready, bus.busy);
      end
      for (int i = 0; i < 30; i++) begin
         if (bus.eng_run === 1'b1) saw_run = 1'b1;
         if (bus.cmp_valid === 1'b1) saw_cmp = 1'b1;
         tick();
      end
      checks++;
      if (saw_run || saw_cmp) begin
         errors++;
         $display("FAIL mid_discard got run=%b cmp=%b want 0 0", saw_run, saw_cmp);
      end
   endtask

   task automatic test_done_filter();
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      tick();
      checks++;
      if (bus.cmp_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_done got v=%b busy=%b want 0 0", bus.cmp_valid, bus.busy);
      end
      drive_job(4'd14, 16'h0E00, 16'h1E00, 16'h2E00);
      tick();
      bus.job_valid = 1'b0;
      wait_run("race_launch14");
      repeat (TC - 1) tick();
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      checks++;
      if (bus.cmp_valid !== 1'b1 || bus.cmp_timeout !== 1'b0 || bus.cmp_id !== 4'd14) begin
         errors++;
         $display("FAIL race got v=%b to=%b id=%0d want 1 0 14",
                  bus.cmp_valid, bus.cmp_timeout, bus.cmp_id);
      end
      bus.cmp_ready = 1'b1;
      tick();
      bus.cmp_ready = 1'b0;
   endtask

   initial begin
      bus.job_valid     = 1'b0;
      bus.job_id        = '0;
      bus.job_src0_addr = '0;
      bus.job_src1_addr = '0;
      bus.job_dst_addr  = '0;
      bus.eng_done      = 1'b0;
      bus.cmp_ready     = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_timeout();
      test_report_hold();
      test_reset_mid();
      test_done_filter();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/merge_scheduler.md
MERGE_SCHEDULER -- requirements
Module: merge_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, width of all partition base addresses.
REQ-002 Parameter ID_WIDTH, default 4, width of job identifiers.
REQ-003 Parameter QUEUE_DEPTH, default 4, job queue entries; power of two, at least 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096, maximum engine cycles per job; at least 2.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 job_valid  in  1  job request present.
REQ-009 job_ready  out  1  queue can accept a job.
REQ-010 job_src0_addr, job_src1_addr, job_dst_addr  in  ADDR_WIDTH each  base addresses of operands A and B, and of the result.
REQ-011 job_id  in  ID_WIDTH  tag returned on completion.
REQ-012 eng_run  out  1  one-cycle start pulse to the merge engine.
REQ-013 eng_src0_addr, eng_src1_addr, eng_dst_addr  out  ADDR_WIDTH each  engine configuration for the active job.
REQ-014 eng_done  in  1  engine completion pulse.
REQ-015 cmp_valid  out  1  completion record present.
REQ-016 cmp_ready  in  1  completion consumer ready.
REQ-017 cmp_id  out  ID_WIDTH  tag of the completed job.
REQ-018 cmp_timeout  out  1  job ended by watchdog, not by eng_done.
REQ-019 busy  out  1  queue non-empty or FSM not IDLE.

Function
REQ-020 Queue SHALL be a FIFO: push on job_valid&&job_ready; job_ready = !full, combinational from the occupancy count only.
REQ-021 Pop SHALL occur only in IDLE with the queue non-empty; no fall-through, so a job pushed in cycle T is poppable in cycle T+1 at the earliest.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged; read/write pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-023 FSM states: IDLE, LAUNCH, RUN, REPORT.
REQ-024 IDLE: on queue non-empty, pop into the active registers (addresses, id) -> LAUNCH; else stay.
REQ-025 LAUNCH: eng_run=1 for exactly this cycle; clear the watchdog counter -> RUN.
REQ-026 RUN: count cycles; eng_done=1 -> REPORT with timeout flag 0; else counter == TIMEOUT_CYCLES-1 -> REPORT with timeout flag 1; eng_done wins when both occur in the same cycle.
REQ-027 REPORT: cmp_valid=1, with cmp_id and cmp_timeout stable, until cmp_ready=1 -> IDLE.
REQ-028 eng_* address outputs SHALL be registered and stable from LAUNCH through REPORT, holding their last value in IDLE.
REQ-029 eng_done outside RUN SHALL be ignored.
REQ-030 Queue acceptance SHALL continue in every FSM state.
REQ-031 Latency: when idle with the queue empty, a job accepted at edge T SHALL give eng_run high in cycle T+2.
REQ-032 The watchdog counter SHALL be wide enough for TIMEOUT_CYCLES-1 and SHALL saturate, never wrap.

Reset
REQ-033 reset_n low SHALL immediately force IDLE, queue empty, all pointers, counters, active registers and outputs 0; job_ready SHALL be 1 after release.
REQ-034 Reset mid-job SHALL discard the queued and active jobs without an eng_run pulse or a completion record.

Structure
REQ-035 Shared package merge_pkg SHALL hold the FSM state enum and the job record struct (src0, src1, dst, id).
REQ-036 The queue SHALL be one sub-module, job_fifo, parameterised by depth and record width.

Verification
REQ-037 One job (0x000, 0x100, 0x200, id 3), eng_done 10 cycles after eng_run -> eng_run at T+2 with addresses correct, cmp_valid with id 3 and timeout 0.
REQ-038 Push 5 jobs back-to-back while the engine is stalled -> job_ready low after 4 accepted; completions in id order 0-4.
REQ-039 Never assert eng_done, TIMEOUT_CYCLES=16 -> cmp_timeout=1 exactly 16 cycles after LAUNCH; the next job launches normally.
REQ-040 Hold cmp_ready=0 for 20 cycles in REPORT -> cmp_valid, cmp_id stable, no new eng_run; pop after release.
REQ-041 Assert reset_n=0 during RUN with 2 jobs queued -> all outputs 0 at once, no completion after release, job_ready=1.
REQ-042 eng_done pulse in IDLE, then eng_done coinciding with timeout -> first ignored; second gives cmp_timeout=0.
